// File: rtl/palette_ram_arbiter_if.sv
// Bus bundle between the palette RAM arbiter, its two requesters
// (pixel serializer, AHB slave) and the single-port palette RAM.
interface palette_ram_arbiter_if;
   logic        lcd_en;
   logic        pix_req;
   logic [7:0]  pix_addr;
   logic        pix_gnt;
   logic [15:0] pix_rdata;
   logic        pix_rvalid;
   logic        ahb_req;
   logic        ahb_wr;
   logic [6:0]  ahb_addr;
   logic [31:0] ahb_wdata;
   logic [31:0] ahb_rdata;
   logic        ahb_done;
   logic        ram_we;
   logic [6:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        busy;

   // Arbiter side of the bundle.
   modport slave (
      input  lcd_en, pix_req, pix_addr, ahb_req, ahb_wr, ahb_addr, ahb_wdata, ram_rdata,
      output pix_gnt, pix_rdata, pix_rvalid, ahb_rdata, ahb_done,
             ram_we, ram_addr, ram_wdata, busy
   );

   // Requester / RAM side of the bundle.
   modport master (
      output lcd_en, pix_req, pix_addr, ahb_req, ahb_wr, ahb_addr, ahb_wdata, ram_rdata,
      input  pix_gnt, pix_rdata, pix_rvalid, ahb_rdata, ahb_done,
             ram_we, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/palette_ram_arbiter.sv
// Palette RAM arbiter: one RAM access per cycle, pixel lookups first,
// AHB accesses forced through after MAX_STALL consecutive denials.
module palette_ram_arbiter #(
   parameter int MAX_STALL = 4,
   parameter int CNT_W     = 4
) (
   input logic                  HCLK,
   input logic                  HRESET,
   palette_ram_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIX  = 2'd1,
      GNT_AHB  = 2'd2
   } gnt_e;

   gnt_e             gnt_s;
   logic             ahb_elig_s;
   logic             force_s;
   logic             pix_win_s;
   logic             ram_we_s;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             ahb_out_q, ahb_out_d;
   logic             ahb_rd_p1_q, ahb_rd_p1_d;
   logic             ahb_done_q, ahb_done_d;
   logic [31:0]      ahb_rdata_q, ahb_rdata_d;
   logic             pix_p1_q, pix_p1_d;
   logic             pix_half_q, pix_half_d;
   logic             pix_rvalid_q, pix_rvalid_d;
   logic [15:0]      pix_rdata_q, pix_rdata_d;
   logic [6:0]       ram_addr_q, ram_addr_d;
   logic [31:0]      ram_wdata_q, ram_wdata_d;

   // Grant selection for the current cycle; nothing is granted while reset is held.
   always_comb begin
      ahb_elig_s = bus.ahb_req & ~ahb_out_q & ~ahb_done_q;
      force_s    = ahb_elig_s & (stall_cnt_q == STALL_LIMIT);
      pix_win_s  = HRESET & bus.lcd_en & ~force_s;
      gnt_s      = GNT_NONE;
      if (!HRESET) begin
         gnt_s = GNT_NONE;
      end else if (!bus.lcd_en) begin
         if (ahb_elig_s) begin
            gnt_s = GNT_AHB;
         end else begin
            gnt_s = GNT_NONE;
         end
      end else if (force_s) begin
         gnt_s = GNT_AHB;
      end else if (bus.pix_req) begin
         gnt_s = GNT_PIX;
      end else if (ahb_elig_s) begin
         gnt_s = GNT_AHB;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   // RAM port drive, response pipelines, stall counter and outstanding flag.
   always_comb begin
      ram_we_s     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      pix_p1_d     = 1'b0;
      pix_half_d   = pix_half_q;
      ahb_rd_p1_d  = 1'b0;
      case (gnt_s)
         GNT_PIX: begin
            ram_addr_d = bus.pix_addr[7:1];
            pix_p1_d   = 1'b1;
            pix_half_d = bus.pix_addr[0];
         end
         GNT_AHB: begin
            ram_addr_d  = bus.ahb_addr;
            ram_we_s    = bus.ahb_wr;
            ahb_rd_p1_d = ~bus.ahb_wr;
            if (bus.ahb_wr) begin
               ram_wdata_d = bus.ahb_wdata;
            end else begin
               ram_wdata_d = ram_wdata_q;
            end
         end
         default: begin
            ram_addr_d = ram_addr_q;
         end
      endcase

      // RAM data is one cycle behind the address, so capture it from the first pipe stage.
      pix_rvalid_d = pix_p1_q;
      if (pix_p1_q) begin
         pix_rdata_d = pix_half_q ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
      end else begin
         pix_rdata_d = pix_rdata_q;
      end

      ahb_done_d = ((gnt_s == GNT_AHB) & bus.ahb_wr) | ahb_rd_p1_q;
      if (ahb_rd_p1_q) begin
         ahb_rdata_d = bus.ram_rdata;
      end else begin
         ahb_rdata_d = ahb_rdata_q;
      end

      if (gnt_s == GNT_AHB) begin
         ahb_out_d = 1'b1;
      end else if (ahb_done_q) begin
         ahb_out_d = 1'b0;
      end else begin
         ahb_out_d = ahb_out_q;
      end

      if (!bus.ahb_req || (gnt_s == GNT_AHB)) begin
         stall_cnt_d = {CNT_W{1'b0}};
      end else if (ahb_elig_s && (stall_cnt_q < STALL_LIMIT)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State and output registers; reset discards any in-flight response.
   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         stall_cnt_q  <= {CNT_W{1'b0}};
         ahb_out_q    <= 1'b0;
         ahb_rd_p1_q  <= 1'b0;
         ahb_done_q   <= 1'b0;
         ahb_rdata_q  <= 32'h0000_0000;
         pix_p1_q     <= 1'b0;
         pix_half_q   <= 1'b0;
         pix_rvalid_q <= 1'b0;
         pix_rdata_q  <= 16'h0000;
         ram_addr_q   <= 7'h00;
         ram_wdata_q  <= 32'h0000_0000;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         ahb_out_q    <= ahb_out_d;
         ahb_rd_p1_q  <= ahb_rd_p1_d;
         ahb_done_q   <= ahb_done_d;
         ahb_rdata_q  <= ahb_rdata_d;
         pix_p1_q     <= pix_p1_d;
         pix_half_q   <= pix_half_d;
         pix_rvalid_q <= pix_rvalid_d;
         pix_rdata_q  <= pix_rdata_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
      end
   end

   assign bus.pix_gnt    = pix_win_s;
   assign bus.pix_rdata  = pix_rdata_q;
   assign bus.pix_rvalid = pix_rvalid_q;
   assign bus.ahb_rdata  = ahb_rdata_q;
   assign bus.ahb_done   = ahb_done_q;
   assign bus.ram_we     = ram_we_s;
   assign bus.ram_addr   = ram_addr_d;
   assign bus.ram_wdata  = ram_wdata_d;
   assign bus.busy       = ahb_out_q | pix_p1_q | pix_rvalid_q;

endmodule

// File: doc/palette_ram_arbiter.md
Name: palette_ram_arbiter

Overview:
Shares the single-port 128x32 colour palette RAM between two requesters: the pixel serializer (palette lookups, 16-bit entries) and the AHB slave (32-bit register-style reads and writes). Pixel lookups get priority. A bounded-starvation counter guarantees AHB progress. The block sits between LCD_slave, pixel_serializer and the palette RAM interface, in the HCLK domain.

Parameters:
MAX_STALL, 4, max consecutive cycles a pending AHB access may be denied before it is forced through (1..15)
CNT_W, 4, width of the stall counter

Ports:
HCLK  in  1  system clock; all logic rising-edge
HRESET  in  1  asynchronous active-low reset
lcd_en  in  1  LCDEN from LCD_CTRL; 0 = pixel requester disabled
pix_req  in  1  pixel lookup request
pix_addr  in  8  palette index 0..255
pix_gnt  out  1  lookup accepted this cycle (handshake = pix_req & pix_gnt)
pix_rdata  out  16  palette entry
pix_rvalid  out  1  pix_rdata valid, 1-cycle pulse
ahb_req  in  1  AHB access request, held until ahb_done
ahb_wr  in  1  1 = write, 0 = read; stable while ahb_req is high
ahb_addr  in  7  RAM word address
ahb_wdata  in  32  write data
ahb_rdata  out  32  read data
ahb_done  out  1  access complete, 1-cycle pulse
ram_we  out  1  RAM write enable
ram_addr  out  7  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after the address is presented
busy  out  1  any access outstanding

Behaviour:
- Reset (HRESET=0, async): pix_gnt, pix_rvalid, ahb_done, ram_we, busy = 0. pix_rdata, ahb_rdata, ram_addr, ram_wdata = 0. Stall counter = 0. Outstanding flags cleared. Any in-flight response is discarded and never delivered after reset.
- At most one RAM access per cycle. The arbiter is combinational on the current cycle. ram_we, ram_addr and ram_wdata are driven from the grant in the same cycle N.
- AHB eligible = ahb_req & ~ahb_out & ~ahb_done. ahb_out is set on grant and cleared when ahb_done pulses.
- Grant priority in cycle N:
  1. If lcd_en=0, pixel is never granted (pix_gnt=0) and an eligible AHB access is issued.
  2. Else if AHB is eligible and stall_cnt==MAX_STALL, AHB is issued and pix_gnt=0.
  3. Else if pix_req=1, pixel is issued (pix_gnt=1).
  4. Else if AHB is eligible, AHB is issued.
- pix_gnt = 1 whenever the pixel would win, whether or not pix_req is asserted (ready-style).
- Stall counter: increments (saturating at MAX_STALL) each cycle AHB is eligible but not issued. Clears to 0 on AHB issue or when ahb_req=0.
- Pixel issue: ram_addr = pix_addr[7:1], ram_we = 0. The half-select bit pix_addr[0] is pipelined. In N+1, pix_rdata <= half ? ram_rdata[31:16] : ram_rdata[15:0], registered. pix_rvalid = 1 in N+2. Latency 2, throughput 1 per cycle.
- AHB read issue: ram_addr = ahb_addr, we = 0. ahb_rdata is registered from ram_rdata. ahb_done = 1 in N+2.
- AHB write issue: ram_we = 1, ram_addr = ahb_addr, ram_wdata = ahb_wdata. ahb_done = 1 in N+1.
- Idle cycles: ram_we = 0; ram_addr holds its previous value.
- A pixel read of a word in the cycle after an AHB write to that word returns the new data.
- lcd_en falling while pixel reads are in flight: in-flight reads complete and deliver pix_rvalid. No new pixel grants.
- busy = ahb_out | any pixel response in flight.

Test Plan:
1. Reset with lcd_en=0; ahb write addr 7'h05, data 32'hA5A5_1234 → ram_we=1 in the issue cycle, ahb_done one cycle later; ahb read addr 5 → ahb_rdata=32'hA5A5_1234 with ahb_done two cycles after issue.
2. lcd_en=1, RAM word 5 = 32'hBEEF_CAFE; pixel reads of index 8'h0A then 8'h0B on back-to-back cycles → pix_rvalid on two consecutive cycles with pix_rdata=16'hCAFE then 16'hBEEF.
3. pix_req held high continuously, AHB read pending (MAX_STALL=4) → pix_gnt=1 for exactly 4 cycles, then 0 for one cycle (AHB issued), then 1 again; ahb_done 2 cycles after the forced slot.
4. AHB write to word 3 and pixel request for index 8'h06 in the same cycle with stall_cnt<MAX_STALL → pixel issued first; write issued later; a pixel read of 8'h07 after ahb_done returns the new upper half.
5. HRESET asserted one cycle after a pixel issue → pix_rvalid never pulses and all outputs are 0 immediately; after release, a normal read succeeds.
6. lcd_en dropped the cycle after two pixel issues → both pix_rvalid pulses delivered; pix_gnt=0 from the drop onward; a pending AHB access is issued immediately.
